branch_pc_ctrl: RTL and testbench

Parametrised successor to the fetch-stage PC-select logic. It drives `pc_select` for the fetch mux and adds a dynamic branch predictor: a table of saturating counters indexed by fetch PC. It tracks the prediction for the instruction in execute, detects mispredicts, trains the table, and keeps saturating branch/mispredict counters for the CSR path. It sits between the fetch stage, the execute-stage branch comparator, and the PC mux.

---
 rtl/branch_pc_ctrl_pkg.sv | 26 ++
 rtl/branch_pc_ctrl_bp_counter_table.sv | 45 ++++
 rtl/branch_pc_ctrl.sv | 103 ++++++++++
 tb/tb_branch_pc_ctrl.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_pc_ctrl_pkg.sv
// Shared encodings for the fetch PC-select path: pc_select codes and RISC-V opcode/funct fields.
package branch_pc_ctrl_pkg;

    localparam logic [2:0] PC_SEL_RESET = 3'd0;
    localparam logic [2:0] PC_SEL_JAL   = 3'd1;
    localparam logic [2:0] PC_SEL_PC4   = 3'd2;
    localparam logic [2:0] PC_SEL_ALU   = 3'd3;
    localparam logic [2:0] PC_SEL_BR    = 3'd4;
    localparam logic [2:0] PC_SEL_XPC4  = 3'd5;

    localparam logic [4:0] OPC_BRANCH_5 = 5'b11000;
    localparam logic [4:0] OPC_JAL_5    = 5'b11011;
    localparam logic [4:0] OPC_JALR_5   = 5'b11001;

    localparam logic [2:0] FNC_BEQ  = 3'b000;
    localparam logic [2:0] FNC_BNE  = 3'b001;
    localparam logic [2:0] FNC_BLT  = 3'b100;
    localparam logic [2:0] FNC_BGE  = 3'b101;
    localparam logic [2:0] FNC_BLTU = 3'b110;
    localparam logic [2:0] FNC_BGEU = 3'b111;

    function automatic logic [4:0] opc5(input logic [31:0] instr);
        return instr[6:2];
    endfunction

endpackage

// File: rtl/branch_pc_ctrl_bp_counter_table.sv
// Table of saturating branch counters: one combinational read port, one
// read-modify-write update port. Reset puts every entry at weakly not-taken.
module bp_counter_table #(
    parameter int BHT_ENTRIES = 32,
    parameter int CTR_BITS    = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [$clog2(BHT_ENTRIES)-1:0] rd_idx,
    output logic [CTR_BITS-1:0]            rd_ctr,
    input  logic                           wr_en,
    input  logic [$clog2(BHT_ENTRIES)-1:0] wr_idx,
    input  logic                           wr_taken
);

    localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'((2 ** (CTR_BITS - 1)) - 1);
    localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
    localparam logic [CTR_BITS-1:0] CTR_ONE  = CTR_BITS'(1);

    logic [CTR_BITS-1:0] ctr_q [BHT_ENTRIES];
    logic [CTR_BITS-1:0] wr_cur;
    logic [CTR_BITS-1:0] wr_next;

    // No bypass: a same-index read in the update cycle returns the old value.
    assign rd_ctr = ctr_q[rd_idx];
    assign wr_cur = ctr_q[wr_idx];

    always_comb begin
        wr_next = wr_cur;
        if (wr_taken) begin
            if (wr_cur != CTR_MAX) wr_next = wr_cur + CTR_ONE;
        end else begin
            if (wr_cur != '0) wr_next = wr_cur - CTR_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < BHT_ENTRIES; i++) ctr_q[i] <= CTR_INIT;
        end else if (wr_en) begin
            ctr_q[wr_idx] <= wr_next;
        end
    end

endmodule

// File: rtl/branch_pc_ctrl.sv
// Fetch PC-select with a dynamic branch predictor: tracks the execute-stage
// prediction, redirects on mispredict/JALR, trains the table, counts branches.
module branch_pc_ctrl
    import branch_pc_ctrl_pkg::*;
#(
    parameter int BHT_ENTRIES = 32,
    parameter int CTR_BITS    = 2,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall,
    input  logic                 bp_en,
    input  logic [31:0]          f_pc,
    input  logic [31:0]          f_instruction,
    input  logic [31:0]          x_instruction,
    input  logic [31:0]          x_pc,
    input  logic                 br_taken,
    output logic [2:0]           pc_select,
    output logic                 f_pred_taken,
    output logic                 flush,
    output logic [CNT_WIDTH-1:0] branch_count,
    output logic [CNT_WIDTH-1:0] mispredict_count
);

    localparam int IDX = $clog2(BHT_ENTRIES);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    logic                boot_q;
    logic                x_valid_q;
    logic                x_pred_q;
    logic [CTR_BITS-1:0] f_ctr;
    logic                f_is_br;
    logic                f_is_jal;
    logic                x_is_br;
    logic                x_is_jalr;
    logic                mispred;
    logic                train;
    logic                unused_bits;

    assign unused_bits = ^{f_pc[31:IDX+2], f_pc[1:0], x_pc[31:IDX+2], x_pc[1:0],
                           f_instruction[31:7], f_instruction[1:0],
                           x_instruction[31:7], x_instruction[1:0]};

    bp_counter_table #(
        .BHT_ENTRIES (BHT_ENTRIES),
        .CTR_BITS    (CTR_BITS)
    ) u_table (
        .clk      (clk),
        .rst      (rst),
        .rd_idx   (f_pc[IDX+1:2]),
        .rd_ctr   (f_ctr),
        .wr_en    (train),
        .wr_idx   (x_pc[IDX+1:2]),
        .wr_taken (br_taken)
    );

    assign f_is_br      = (opc5(f_instruction) == OPC_BRANCH_5);
    assign f_is_jal     = (opc5(f_instruction) == OPC_JAL_5);
    assign f_pred_taken = f_is_br & bp_en & f_ctr[CTR_BITS-1];

    assign x_is_br   = x_valid_q & (opc5(x_instruction) == OPC_BRANCH_5);
    assign x_is_jalr = x_valid_q & (opc5(x_instruction) == OPC_JALR_5);
    assign mispred   = x_is_br & (br_taken != x_pred_q);
    assign flush     = ~boot_q & (mispred | x_is_jalr);
    assign train     = x_is_br & ~stall;

    always_comb begin
        pc_select = PC_SEL_PC4;
        if (boot_q)                    pc_select = PC_SEL_RESET;
        else if (x_is_jalr)            pc_select = PC_SEL_ALU;
        else if (mispred && br_taken)  pc_select = PC_SEL_ALU;
        else if (mispred)              pc_select = PC_SEL_XPC4;
        else if (f_is_jal)             pc_select = PC_SEL_JAL;
        else if (f_pred_taken)         pc_select = PC_SEL_BR;
    end

    // boot_q only ever falls; the instruction seen in X during boot is never valid.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            boot_q    <= 1'b1;
            x_valid_q <= 1'b0;
            x_pred_q  <= 1'b0;
        end else begin
            boot_q <= 1'b0;
            if (!stall) begin
                x_valid_q <= ~flush;
                x_pred_q  <= flush ? 1'b0 : f_pred_taken;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            branch_count     <= '0;
            mispredict_count <= '0;
        end else if (train) begin
            if (branch_count != '1) branch_count <= branch_count + CNT_ONE;
            if (mispred && (mispredict_count != '1)) mispredict_count <= mispredict_count + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_branch_pc_ctrl.sv
// Bench for branch_pc_ctrl: hand-computed vector table, multi-cycle corner
// sequences and random traffic against a behavioural pipeline model.
module tb_branch_pc_ctrl;

    localparam int BHT = 32;
    localparam int CB  = 2;
    localparam int CW  = 4;
    localparam int CTR_MAX_M = (1 << CB) - 1;
    localparam int CNT_MAX_M = (1 << CW) - 1;

    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] BR   = 32'h0000_0063;
    localparam logic [31:0] JAL  = 32'h0000_006f;
    localparam logic [31:0] JALR = 32'h0000_0067;

    logic          clk;
    logic          rst;
    logic          stall;
    logic          bp_en;
    logic [31:0]   f_pc;
    logic [31:0]   f_instruction;
    logic [31:0]   x_instruction;
    logic [31:0]   x_pc;
    logic          br_taken;
    logic [2:0]    pc_select;
    logic          f_pred_taken;
    logic          flush;
    logic [CW-1:0] branch_count;
    logic [CW-1:0] mispredict_count;

    int total;
    int bad;

    branch_pc_ctrl #(
        .BHT_ENTRIES (BHT),
        .CTR_BITS    (CB),
        .CNT_WIDTH   (CW)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .stall            (stall),
        .bp_en            (bp_en),
        .f_pc             (f_pc),
        .f_instruction    (f_instruction),
        .x_instruction    (x_instruction),
        .x_pc             (x_pc),
        .br_taken         (br_taken),
        .pc_select        (pc_select),
        .f_pred_taken     (f_pred_taken),
        .flush            (flush),
        .branch_count     (branch_count),
        .mispredict_count (mispredict_count)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int m_ctr [BHT];
    int m_bc;
    int m_mc;
    bit m_boot;
    bit m_xv;
    bit m_xp;
    int e_sel;
    bit e_pred;
    bit e_flush;
    bit e_xbr;
    bit e_mis;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < BHT; i++) m_ctr[i] = (1 << (CB - 1)) - 1;
        m_bc   = 0;
        m_mc   = 0;
        m_boot = 1'b1;
        m_xv   = 1'b0;
        m_xp   = 1'b0;
    endtask

    // Drive one cycle's inputs, predict the combinational outputs, compare.
    task automatic drive_and_check(input logic s, input logic b, input logic [31:0] fpc,
                                   input logic [31:0] fin, input logic [31:0] xpc,
                                   input logic [31:0] xin, input logic bt);
        logic [4:0] fop;
        logic [4:0] xop;
        int         fidx;
        bit         xj;
        stall = s; bp_en = b; f_pc = fpc; f_instruction = fin;
        x_pc = xpc; x_instruction = xin; br_taken = bt;
        #1;
        fop    = fin[6:2];
        xop    = xin[6:2];
        fidx   = int'((fpc >> 2) % BHT);
        e_pred = (fop == 5'b11000) && b && (m_ctr[fidx] >= (1 << (CB - 1)));
        e_xbr  = m_xv && (xop == 5'b11000);
        xj     = m_xv && (xop == 5'b11001);
        e_mis  = e_xbr && (bt != m_xp);
        e_flush = !m_boot && (e_mis || xj);
        if (m_boot)               e_sel = 0;
        else if (xj)              e_sel = 3;
        else if (e_mis && bt)     e_sel = 3;
        else if (e_mis)           e_sel = 5;
        else if (fop == 5'b11011) e_sel = 1;
        else if (e_pred)          e_sel = 4;
        else                      e_sel = 2;
        check("pc_select", 32'(pc_select), e_sel);
        check("f_pred_taken", 32'(f_pred_taken), 32'(e_pred));
        check("flush", 32'(flush), 32'(e_flush));
        check("branch_count", 32'(branch_count), m_bc);
        check("mispredict_count", 32'(mispredict_count), m_mc);
    endtask

    // Clock edge: advance the model with the same inputs, return at negedge.
    task automatic advance();
        int xidx;
        @(posedge clk);
        if (rst) begin
            if (!stall) begin
                if (e_xbr) begin
                    xidx = int'((x_pc >> 2) % BHT);
                    if (br_taken) m_ctr[xidx] = (m_ctr[xidx] < CTR_MAX_M) ? m_ctr[xidx] + 1 : CTR_MAX_M;
                    else          m_ctr[xidx] = (m_ctr[xidx] > 0) ? m_ctr[xidx] - 1 : 0;
                    m_bc = (m_bc < CNT_MAX_M) ? m_bc + 1 : CNT_MAX_M;
                    if (e_mis) m_mc = (m_mc < CNT_MAX_M) ? m_mc + 1 : CNT_MAX_M;
                end
                m_xv = !e_flush;
                m_xp = e_flush ? 1'b0 : e_pred;
            end
            m_boot = 1'b0;
        end
        @(negedge clk);
    endtask

    // Asserts reset mid-cycle with whatever inputs are present, checks the
    // immediate clear, holds across two edges, releases just after a negedge.
    task automatic reset_dut();
        rst = 1'b0;
        #1;
        model_reset();
        check("rst_pc_select", 32'(pc_select), 0);
        check("rst_flush", 32'(flush), 0);
        check("rst_branch_count", 32'(branch_count), 0);
        check("rst_mispredict_count", 32'(mispredict_count), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        bp_en;
        logic [31:0] f_pc;
        logic [31:0] f_instr;
        logic [31:0] x_pc;
        logic [31:0] x_instr;
        logic        br_taken;
        int          sel;
        logic        pred;
        logic        flush;
        int          bc;
        int          mc;
    } vec_t;

    vec_t vecs [15];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached before end of test");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r_fi;
        logic [31:0] r_xi;
        int          pick;
        bit          sat_dir [13];
        bit          sat_exp [13];
        total = 0;
        bad   = 0;
        stall = 1'b0; bp_en = 1'b1; f_pc = '0; f_instruction = NOP;
        x_pc = '0; x_instruction = NOP; br_taken = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        reset_dut();

        // Row 0 is the boot cycle; counter on PC 0x40 trains 01->10->11.
        vecs[0]  = '{1'b1, 32'h00, NOP,  32'h00, NOP,  1'b0, 0, 1'b0, 1'b0, 0, 0};
        vecs[1]  = '{1'b1, 32'h04, NOP,  32'h00, NOP,  1'b0, 2, 1'b0, 1'b0, 0, 0};
        vecs[2]  = '{1'b1, 32'h40, BR,   32'h04, NOP,  1'b0, 2, 1'b0, 1'b0, 0, 0};
        vecs[3]  = '{1'b1, 32'h44, NOP,  32'h40, BR,   1'b1, 3, 1'b0, 1'b1, 0, 0};
        vecs[4]  = '{1'b1, 32'h40, BR,   32'h44, NOP,  1'b0, 4, 1'b1, 1'b0, 1, 1};
        vecs[5]  = '{1'b1, 32'h44, NOP,  32'h40, BR,   1'b1, 2, 1'b0, 1'b0, 1, 1};
        vecs[6]  = '{1'b1, 32'h40, BR,   32'h44, NOP,  1'b0, 4, 1'b1, 1'b0, 2, 1};
        vecs[7]  = '{1'b1, 32'h44, NOP,  32'h40, BR,   1'b0, 5, 1'b0, 1'b1, 2, 1};
        vecs[8]  = '{1'b1, 32'h44, NOP,  32'h40, BR,   1'b1, 2, 1'b0, 1'b0, 3, 2};
        vecs[9]  = '{1'b1, 32'h48, JAL,  32'h44, NOP,  1'b0, 1, 1'b0, 1'b0, 3, 2};
        vecs[10] = '{1'b1, 32'h4c, NOP,  32'h48, JALR, 1'b0, 3, 1'b0, 1'b1, 3, 2};
        vecs[11] = '{1'b1, 32'h50, NOP,  32'h48, JALR, 1'b0, 2, 1'b0, 1'b0, 3, 2};
        vecs[12] = '{1'b0, 32'h40, BR,   32'h50, NOP,  1'b0, 2, 1'b0, 1'b0, 3, 2};
        vecs[13] = '{1'b0, 32'h44, NOP,  32'h40, BR,   1'b1, 3, 1'b0, 1'b1, 3, 2};
        vecs[14] = '{1'b1, 32'h40, BR,   32'h44, NOP,  1'b0, 4, 1'b1, 1'b0, 4, 3};

        for (int i = 0; i < 15; i++) begin
            drive_and_check(1'b0, vecs[i].bp_en, vecs[i].f_pc, vecs[i].f_instr,
                            vecs[i].x_pc, vecs[i].x_instr, vecs[i].br_taken);
            check($sformatf("vec%0d_sel", i), 32'(pc_select), vecs[i].sel);
            check($sformatf("vec%0d_pred", i), 32'(f_pred_taken), 32'(vecs[i].pred));
            check($sformatf("vec%0d_flush", i), 32'(flush), 32'(vecs[i].flush));
            check($sformatf("vec%0d_bcnt", i), 32'(branch_count), vecs[i].bc);
            check($sformatf("vec%0d_mcnt", i), 32'(mispredict_count), vecs[i].mc);
            advance();
        end

        // Saturation on PC 0x80: resolve in X, then read the prediction back.
        reset_dut();
        drive_and_check(1'b0, 1'b1, 32'h84, NOP, 32'h84, NOP, 1'b0);
        advance();
        sat_dir = '{1, 1, 1, 1, 1, 0, 1, 0, 0, 0, 0, 0, 1};
        sat_exp = '{1, 1, 1, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0};
        for (int k = 0; k < 13; k++) begin
            drive_and_check(1'b0, 1'b1, 32'h84, NOP, 32'h80, BR, sat_dir[k]);
            advance();
            drive_and_check(1'b0, 1'b1, 32'h80, BR, 32'h84, NOP, 1'b0);
            check($sformatf("sat%0d_pred", k), 32'(f_pred_taken), 32'(sat_exp[k]));
            advance();
        end
        for (int k = 0; k < 7; k++) begin
            drive_and_check(1'b0, 1'b1, 32'h84, NOP, 32'h80, BR, 1'($urandom_range(0, 1)));
            advance();
            drive_and_check(1'b0, 1'b1, 32'h80, BR, 32'h84, NOP, 1'b0);
            advance();
        end
        drive_and_check(1'b0, 1'b1, 32'h84, NOP, 32'h84, NOP, 1'b0);
        check("sat_branch_count", 32'(branch_count), 15);
        advance();

        // Stall: branch held in X for three stalled cycles, trains once.
        reset_dut();
        drive_and_check(1'b0, 1'b1, 32'h84, NOP, 32'h84, NOP, 1'b0);
        advance();
        drive_and_check(1'b0, 1'b1, 32'h80, BR, 32'h84, NOP, 1'b0);
        advance();
        for (int k = 0; k < 3; k++) begin
            drive_and_check(1'b1, 1'b1, 32'h84, NOP, 32'h80, BR, 1'b1);
            check($sformatf("stall%0d_flush", k), 32'(flush), 1);
            check($sformatf("stall%0d_bcnt", k), 32'(branch_count), 0);
            advance();
        end
        drive_and_check(1'b0, 1'b1, 32'h84, NOP, 32'h80, BR, 1'b1);
        check("stall_release_bcnt", 32'(branch_count), 0);
        advance();
        drive_and_check(1'b0, 1'b1, 32'h80, BR, 32'h84, NOP, 1'b0);
        check("stall_after_bcnt", 32'(branch_count), 1);
        check("stall_after_mcnt", 32'(mispredict_count), 1);
        check("stall_after_pred", 32'(f_pred_taken), 1);
        advance();

        // Random traffic over aliasing PCs, with periodic mid-run resets.
        reset_dut();
        for (int n = 0; n < 800; n++) begin
            if (n % 200 == 199) reset_dut();
            pick = $urandom_range(0, 9);
            r_fi = (pick < 4) ? (($urandom & 32'hffff_ff80) | BR) :
                   (pick == 4) ? JAL : (pick == 5) ? JALR :
                   (pick == 9) ? 32'($urandom) : NOP;
            pick = $urandom_range(0, 9);
            r_xi = (pick < 5) ? (($urandom & 32'hffff_ff80) | BR) :
                   (pick == 5) ? JALR : (pick == 9) ? 32'($urandom) : NOP;
            drive_and_check(1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 7) != 0),
                            32'h100 + 32'($urandom_range(0, 3)) * 128 + 32'($urandom_range(0, 3)) * 4,
                            r_fi,
                            32'h100 + 32'($urandom_range(0, 3)) * 128 + 32'($urandom_range(0, 3)) * 4,
                            r_xi, 1'($urandom_range(0, 1)));
            advance();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
